// File: rtl/mic_fifo_ram.sv
// mic_fifo_ram: dual-port sample buffer with registered read and post-reset clear sweep.
// Define MIC_FIFO_WR_FWD_EN for write-first bypass on same-address read/write.
module mic_fifo_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_we,
  input  logic [ADDR_WIDTH-1:0] fifo_wr_addr,
  input  logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic [ADDR_WIDTH-1:0] fifo_rd_addr,
  output logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  init_done
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  fwd;
`ifdef MIC_FIFO_WR_FWD_EN
  assign fwd = fifo_we && (fifo_wr_addr == fifo_rd_addr);
`else
  assign fwd = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= INIT;
      clr_cnt      <= '0;
      init_done    <= 1'b0;
      fifo_rd_data <= '0;
    end else if (state == INIT) begin
      clr_cnt      <= clr_cnt + 1'b1;
      fifo_rd_data <= '0;
      if (&clr_cnt) begin
        init_done <= 1'b1;
        state     <= RUN;
      end
    end else begin
      fifo_rd_data <= fwd ? fifo_wr_data : mem[fifo_rd_addr];
    end
  end
  // Storage has no reset: an asserted rst leaves contents intact until the next sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) mem[clr_cnt] <= '0;
      else if (fifo_we) mem[fifo_wr_addr] <= fifo_wr_data;
    end
  end
endmodule

// File: tb/tb_mic_fifo_ram.sv
// tb_mic_fifo_ram: randomized self-checking bench for mic_fifo_ram against an array model.
module tb_mic_fifo_ram;
  localparam int AW = 6, DW = 18, DEPTH = 64;
`ifdef MIC_FIFO_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 0, rst = 0, we = 0, done;
  logic [AW-1:0] wa = 0, ra = 0;
  logic [DW-1:0] wd = 0, rd;
  int checks = 0, errors = 0;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd = 0;
  logic m_done = 0;
  int m_cleared = 0;

  mic_fifo_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .fifo_we(we), .fifo_wr_addr(wa), .fifo_wr_data(wd),
    .fifo_rd_addr(ra), .fifo_rd_data(rd), .init_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the memory is cleared one word per edge for DEPTH edges, then serves reads/writes.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_rd = 0; m_done = 0; m_cleared = 0;
    end else if (m_cleared < DEPTH) begin
      m_mem[m_cleared] = 0; m_rd = 0; m_cleared++;
      if (m_cleared == DEPTH) m_done = 1;
    end else begin
      m_rd = (FWD && we && wa == ra) ? wd : m_mem[ra];
      if (we) m_mem[wa] = wd;
    end
    #1;
    chk("rd_data", 32'(rd), 32'(m_rd));
    chk("init_done", 32'(done), 32'(m_done));
  endtask

  task automatic release_and_sweep(input int rst_at);
    rst = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      we = ($urandom_range(0, 3) == 0); wa = AW'($urandom); wd = DW'($urandom); ra = AW'($urandom);
      if (i == 10) begin we = 1; wa = 3; wd = 18'h3FFFF; end
      if (i == rst_at) begin rst = 0; tick(); return; end
      tick();
      chk("init_edge", 32'(done), 32'(i == DEPTH));
    end
    we = 0;
  endtask

  task automatic read_all_zero();
    we = 0;
    for (int k = 0; k < DEPTH; k++) begin
      ra = AW'(k); tick();
      chk("zero_read", 32'(rd), 0);
    end
  endtask

  initial begin
    rst = 0;
    repeat (3) tick();
    chk("rst_done", 32'(done), 0);
    release_and_sweep(0);
    read_all_zero();
    ra = 3; tick(); chk("init_write_ignored", 32'(rd), 0);
    for (int k = 0; k < DEPTH; k++) begin
      we = 1; wa = AW'(k); wd = DW'(k + 'h100); tick();
    end
    we = 0;
    for (int k = 0; k < DEPTH; k++) begin
      ra = AW'(k); tick(); chk("sweep", 32'(rd), 32'(k + 'h100));
    end
    we = 1; wa = 5; wd = 18'h00AAA; ra = 0; tick();
    wd = 18'h15555; ra = 5; tick();
    chk("collision", 32'(rd), FWD ? 32'h15555 : 32'h00AAA);
    we = 0; tick(); chk("collision_next", 32'(rd), 32'h15555);
    we = 1; wa = 63; wd = 18'h3FFFF; ra = 1; tick();
    we = 0; ra = 63; tick(); chk("full_width", 32'(rd), 32'h3FFFF);
    ra = 0; tick(); chk("addr0_intact", 32'(rd), 32'h100);
    for (int i = 0; i < 600; i++) begin
      we = $urandom_range(0, 1) == 1;
      wa = (i % 3 == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra = (i % 3 == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wd = DW'($urandom);
      tick();
    end
    we = 0; rst = 0; tick();
    chk("run_reset_done", 32'(done), 0);
    release_and_sweep(41);
    release_and_sweep(0);
    read_all_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
